// File: rtl/scanline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scanline_sequencer
// Purpose  : Composite-video scanout timing. Runs the h/v counters, generates
//            sync and active-video flags, prefetches one BRAM line per visible
//            line into a line register and serialises it into BPP-bit pixels.
// Revision : 1.0  initial release
// ============================================================================
module scanline_sequencer #(
    parameter int ADDR_W            = 10,
    parameter int DATA_W            = 300,
    parameter int BPP               = 4,
    parameter int CLKS_PER_LINE     = 1728,
    parameter int SYNC_CLKS         = 127,
    parameter int ACTIVE_START      = 284,
    parameter int CLKS_PER_PIXEL    = 18,
    parameter int LINES_PER_FRAME   = 625,
    parameter int VSYNC_LINES       = 5,
    parameter int FIRST_ACTIVE_LINE = 17,
    parameter int ACTIVE_LINES      = 608
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_EN,
    output logic              o_RD_EN,
    output logic [ADDR_W-1:0] o_RD_ADDR,
    input  logic [DATA_W-1:0] i_RD_DATA,
    output logic              o_SYNC,
    output logic              o_ACTIVE,
    output logic [BPP-1:0]    o_PIXEL,
    output logic              o_LINE_START,
    output logic              o_FRAME_START
);

    localparam int PIXELS     = DATA_W / BPP;
    localparam int ACTIVE_END = ACTIVE_START + PIXELS * CLKS_PER_PIXEL;
    // One spare value of headroom so the end-of-window constants always fit.
    localparam int HW = $clog2(CLKS_PER_LINE + 1);
    localparam int VW = $clog2(LINES_PER_FRAME + 1);
    localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int SW = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [HW-1:0] H_LAST      = HW'(CLKS_PER_LINE - 1);
    localparam logic [HW-1:0] H_SYNC      = HW'(SYNC_CLKS);
    localparam logic [HW-1:0] H_CAPTURE   = HW'(SYNC_CLKS + 1);
    localparam logic [HW-1:0] H_VSYNC_END = HW'(CLKS_PER_LINE - SYNC_CLKS);
    localparam logic [HW-1:0] H_ACT_START = HW'(ACTIVE_START);
    localparam logic [HW-1:0] H_ACT_END   = HW'(ACTIVE_END);
    localparam logic [VW-1:0] V_LAST      = VW'(LINES_PER_FRAME - 1);
    localparam logic [VW-1:0] V_VSYNC     = VW'(VSYNC_LINES);
    localparam logic [VW-1:0] V_FIRST     = VW'(FIRST_ACTIVE_LINE);
    localparam logic [VW-1:0] V_ACT_END   = VW'(FIRST_ACTIVE_LINE + ACTIVE_LINES);
    localparam logic [SW-1:0] S_LAST      = SW'(CLKS_PER_PIXEL - 1);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_PORCH  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_TAIL   = 2'd3
    } line_state_t;

    line_state_t       state, next_state;
    logic              running;
    logic [HW-1:0]     h, nh;
    logic [VW-1:0]     v, nv;
    logic [SW-1:0]     sub, nsub;
    logic [PW-1:0]     p, np;
    logic [DATA_W-1:0] line_reg;
    logic [BW-1:0]     pix_base;
    logic              vsync_line, active_line, cur_active_line, fetch;

    // Next counter position; the first enabled edge always lands on (0,0).
    always_comb begin
        nh = '0;
        nv = '0;
        if (running) begin
            if (h == H_LAST) begin
                nh = '0;
                nv = (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                nh = h + 1'b1;
                nv = v;
            end
        end
    end

    // Line classification for the upcoming position and the current one.
    always_comb begin
        vsync_line      = (nv < V_VSYNC);
        active_line     = (nv >= V_FIRST) && (nv < V_ACT_END);
        cur_active_line = (v >= V_FIRST) && (v < V_ACT_END);
        fetch           = active_line && (nh == H_SYNC);
    end

    // Per-line phase: SYNC -> PORCH -> ACTIVE (visible lines) -> TAIL.
    always_comb begin
        next_state = state;
        if (nh == '0) begin
            next_state = ST_SYNC;
        end else begin
            case (state)
                ST_SYNC:   if (nh == H_SYNC) next_state = ST_PORCH;
                ST_PORCH:  if (nh == H_ACT_START)
                               next_state = active_line ? ST_ACTIVE : ST_TAIL;
                ST_ACTIVE: if (nh == H_ACT_END) next_state = ST_TAIL;
                default:   next_state = state;
            endcase
        end
    end

    // Pixel sub-counter and index; both restart on entry to the window.
    always_comb begin
        nsub = '0;
        np   = '0;
        if (next_state == ST_ACTIVE && state == ST_ACTIVE) begin
            if (sub == S_LAST) begin
                nsub = '0;
                np   = p + 1'b1;
            end else begin
                nsub = sub + 1'b1;
                np   = p;
            end
        end
        pix_base = BW'(np * BPP);
    end

    // Position counters and phase register; disable parks everything at zero.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            running <= 1'b0;
            h       <= '0;
            v       <= '0;
            sub     <= '0;
            p       <= '0;
            state   <= ST_SYNC;
        end else if (!i_EN) begin
            running <= 1'b0;
            h       <= '0;
            v       <= '0;
            sub     <= '0;
            p       <= '0;
            state   <= ST_SYNC;
        end else begin
            running <= 1'b1;
            h       <= nh;
            v       <= nv;
            sub     <= nsub;
            p       <= np;
            state   <= next_state;
        end
    end

    // Line register: BRAM data is valid in the cycle after the read strobe.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            line_reg <= '0;
        end else if (i_EN && running && cur_active_line && h == H_CAPTURE) begin
            line_reg <= i_RD_DATA;
        end
    end

    // Registered outputs describing the position the counters move to.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            o_RD_EN       <= 1'b0;
            o_RD_ADDR     <= '0;
            o_SYNC        <= 1'b0;
            o_ACTIVE      <= 1'b0;
            o_PIXEL       <= '0;
            o_LINE_START  <= 1'b0;
            o_FRAME_START <= 1'b0;
        end else if (!i_EN) begin
            o_RD_EN       <= 1'b0;
            o_RD_ADDR     <= '0;
            o_SYNC        <= 1'b0;
            o_ACTIVE      <= 1'b0;
            o_PIXEL       <= '0;
            o_LINE_START  <= 1'b0;
            o_FRAME_START <= 1'b0;
        end else begin
            o_RD_EN       <= fetch;
            if (fetch) begin
                o_RD_ADDR <= ADDR_W'(nv - V_FIRST);
            end
            o_SYNC        <= vsync_line ? (nh < H_VSYNC_END) : (nh < H_SYNC);
            o_ACTIVE      <= (next_state == ST_ACTIVE);
            o_PIXEL       <= (next_state == ST_ACTIVE) ? line_reg[pix_base +: BPP] : '0;
            o_LINE_START  <= (nh == '0);
            o_FRAME_START <= (nh == '0) && (nv == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scanline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scanline_sequencer
// Purpose  : Self-checking bench for scanline_sequencer using a reduced-size
//            raster, a synchronous BRAM model and a position-based reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_scanline_sequencer;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int BPP   = 4;
    localparam int CPL   = 80;
    localparam int SYNC  = 7;
    localparam int AS    = 12;
    localparam int CPP   = 3;
    localparam int LINES = 24;
    localparam int VS    = 3;
    localparam int FIRST = 8;
    localparam int AL    = 16;
    localparam int PIX   = DW / BPP;
    localparam int AE    = AS + PIX * CPP;
    localparam int FRAME = LINES * CPL;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [DW-1:0]  rd_data;
    logic           sync;
    logic           active;
    logic [BPP-1:0] pixel;
    logic           ls;
    logic           fs;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [AL];

    // Reference position and state
    int ev, eh, exp_addr;
    bit m_run, m_zero;

    scanline_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .BPP(BPP), .CLKS_PER_LINE(CPL),
        .SYNC_CLKS(SYNC), .ACTIVE_START(AS), .CLKS_PER_PIXEL(CPP),
        .LINES_PER_FRAME(LINES), .VSYNC_LINES(VS),
        .FIRST_ACTIVE_LINE(FIRST), .ACTIVE_LINES(AL)
    ) dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_EN(en),
        .o_RD_EN(rd_en), .o_RD_ADDR(rd_addr), .i_RD_DATA(rd_data),
        .o_SYNC(sync), .o_ACTIVE(active), .o_PIXEL(pixel),
        .o_LINE_START(ls), .o_FRAME_START(fs)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM: one-cycle read latency, garbage when not reading
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= $urandom;
    end

    function automatic bit m_line_active(int v);
        return (v >= FIRST) && (v < FIRST + AL);
    endfunction

    function automatic bit m_sync(int v, int h);
        if (v < VS) return h < (CPL - SYNC);
        return h < SYNC;
    endfunction

    function automatic bit m_rd(int v, int h);
        return m_line_active(v) && (h == SYNC);
    endfunction

    function automatic bit m_act(int v, int h);
        return m_line_active(v) && (h >= AS) && (h < AE);
    endfunction

    function automatic logic [BPP-1:0] m_pix(int v, int h);
        logic [DW-1:0] w;
        int k;
        if (!m_act(v, h)) return '0;
        w = mem[v - FIRST];
        k = (h - AS) / CPP;
        return w[k*BPP +: BPP];
    endfunction

    // Advance one clock and move the reference position accordingly
    task automatic tick();
        bit en_s, rst_s;
        en_s  = en;
        rst_s = rst_n;
        @(posedge clk);
        #1;
        if (!rst_s || !en_s) begin
            m_run = 0; m_zero = 1; ev = 0; eh = 0; exp_addr = 0;
        end else begin
            m_zero = 0;
            if (!m_run) begin
                m_run = 1; ev = 0; eh = 0;
            end else begin
                eh++;
                if (eh == CPL) begin
                    eh = 0;
                    ev++;
                    if (ev == LINES) ev = 0;
                end
            end
            if (m_rd(ev, eh)) exp_addr = ev - FIRST;
        end
    endtask

    task automatic goto(input int v, input int h);
        int n;
        n = 0;
        while (!(m_run && ev == v && eh == h) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 2 * FRAME) begin
            errors++;
            $display("FAIL goto: position (%0d,%0d) not reached, at (%0d,%0d)", v, h, ev, eh);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rd_en, rd_addr, sync, active, pixel, ls, fs} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {rd_en, rd_addr, sync, active, pixel, ls, fs});
        end
        m_run = 0; m_zero = 1; ev = 0; eh = 0; exp_addr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({fs, ls, sync, active, rd_en} !== 5'b11100) begin
            errors++;
            $display("FAIL first_edge: fs/ls/sync/active/rd got %b expected 11100", {fs, ls, sync, active, rd_en});
        end
    endtask

    task automatic test_frame_period();
        int n, rdc, actc;
        n = 0; rdc = 0; actc = 0;
        do begin
            tick();
            n++;
            if (rd_en)  rdc++;
            if (active) actc++;
        end while (fs !== 1'b1 && n < FRAME + 10);
        checks++;
        if (n !== FRAME) begin
            errors++;
            $display("FAIL frame_period: got %0d cycles expected %0d", n, FRAME);
        end
        checks++;
        if (rdc !== AL) begin
            errors++;
            $display("FAIL reads_per_frame: got %0d expected %0d", rdc, AL);
        end
        checks++;
        if (actc !== AL * PIX * CPP) begin
            errors++;
            $display("FAIL active_cycles: got %0d expected %0d", actc, AL * PIX * CPP);
        end
    endtask

    task automatic test_vsync_shape();
        int hi, lo, bad, rdc;
        goto(0, 0);
        hi = 0; lo = 0; bad = 0;
        for (int i = 0; i < CPL; i++) begin
            if (sync) hi++; else lo++;
            if (sync !== (i < CPL - SYNC)) bad++;
            if (i < CPL - 1) tick();
        end
        checks++;
        if (hi !== CPL - SYNC || lo !== SYNC || bad !== 0) begin
            errors++;
            $display("FAIL vsync_line: high=%0d low=%0d misplaced=%0d expected high=%0d low=%0d", hi, lo, bad, CPL - SYNC, SYNC);
        end
        goto(VS, 0);
        hi = 0; lo = 0; bad = 0; rdc = 0;
        for (int i = 0; i < CPL; i++) begin
            if (sync) hi++; else lo++;
            if (sync !== (i < SYNC)) bad++;
            if (rd_en) rdc++;
            if (i < CPL - 1) tick();
        end
        checks++;
        if (hi !== SYNC || lo !== CPL - SYNC || bad !== 0) begin
            errors++;
            $display("FAIL blank_line_sync: high=%0d low=%0d misplaced=%0d expected high=%0d low=%0d", hi, lo, bad, SYNC, CPL - SYNC);
        end
        checks++;
        if (rdc !== 0) begin
            errors++;
            $display("FAIL blank_line_read: got %0d reads expected 0", rdc);
        end
    endtask

    task automatic test_active_fetch();
        logic [DW-1:0] pat;
        int rise, fall, bad, lastpix, afterpix;
        goto(1, 0);
        for (int k = 0; k < PIX; k++) pat[k*BPP +: BPP] = BPP'(k % 16);
        mem[0] = pat;
        goto(FIRST, SYNC);
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== AW'(0)) begin
            errors++;
            $display("FAIL fetch_strobe: rd_en=%b addr=%0d expected 1 and 0", rd_en, rd_addr);
        end
        rise = -1; fall = -1; bad = 0; lastpix = -1; afterpix = -1;
        for (int h = SYNC; h < CPL; h++) begin
            if (active && rise < 0) rise = h;
            if (!active && rise >= 0 && fall < 0) begin fall = h; afterpix = pixel; end
            if (active && pixel !== BPP'(((h - AS) / CPP) % 16)) bad++;
            if (h == AE - 1) lastpix = pixel;
            if (h < CPL - 1) tick();
        end
        checks++;
        if (rise !== AS || fall !== AE) begin
            errors++;
            $display("FAIL active_window: rise=%0d fall=%0d expected %0d and %0d", rise, fall, AS, AE);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL pixel_steps: got %0d wrong pixel cycles expected 0", bad);
        end
        checks++;
        if (lastpix !== (PIX - 1) % 16 || afterpix !== 0) begin
            errors++;
            $display("FAIL pixel_edges: last=%0d after=%0d expected %0d and 0", lastpix, afterpix, (PIX - 1) % 16);
        end
    endtask

    task automatic test_addr_wrap();
        int rdc;
        goto(LINES - 1, SYNC);
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== AW'(AL - 1)) begin
            errors++;
            $display("FAIL last_fetch: rd_en=%b addr=%0d expected 1 and %0d", rd_en, rd_addr, AL - 1);
        end
        goto(0, 0);
        checks++;
        if (fs !== 1'b1) begin
            errors++;
            $display("FAIL wrap_frame_start: got %b expected 1", fs);
        end
        rdc = 0;
        for (int i = 0; i < CPL; i++) begin
            if (rd_en) rdc++;
            tick();
        end
        checks++;
        if (rdc !== 0) begin
            errors++;
            $display("FAIL wrap_line0_read: got %0d reads expected 0", rdc);
        end
        goto(FIRST, SYNC);
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== AW'(0)) begin
            errors++;
            $display("FAIL refetch_zero: rd_en=%b addr=%0d expected 1 and 0", rd_en, rd_addr);
        end
    endtask

    task automatic test_disable_midline();
        int bad;
        goto(FIRST + 2, 20);
        en = 1'b0;
        tick();
        checks++;
        if ({rd_en, rd_addr, sync, active, pixel, ls, fs} !== '0) begin
            errors++;
            $display("FAIL disable_outputs: got %h expected 0", {rd_en, rd_addr, sync, active, pixel, ls, fs});
        end
        mem[0] = $urandom;
        bad = 0;
        repeat (100) begin
            tick();
            if ({rd_en, rd_addr, sync, active, pixel, ls, fs} !== '0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL disabled_idle: got %0d nonzero cycles expected 0", bad);
        end
        en = 1'b1;
        tick();
        checks++;
        if ({fs, ls, sync} !== 3'b111) begin
            errors++;
            $display("FAIL reenable_start: fs/ls/sync got %b expected 111", {fs, ls, sync});
        end
        goto(FIRST, SYNC);
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== AW'(0)) begin
            errors++;
            $display("FAIL reenable_fetch: rd_en=%b addr=%0d expected 1 and 0", rd_en, rd_addr);
        end
        goto(FIRST, AS + 3 * CPP);
        checks++;
        if (pixel !== mem[0][3*BPP +: BPP]) begin
            errors++;
            $display("FAIL reenable_pixel: got %h expected %h", pixel, mem[0][3*BPP +: BPP]);
        end
    endtask

    task automatic test_async_reset();
        goto(FIRST + 5, 20);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, rd_addr, sync, active, pixel, ls, fs} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", {rd_en, rd_addr, sync, active, pixel, ls, fs});
        end
        m_run = 0; m_zero = 1; ev = 0; eh = 0; exp_addr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({fs, ls, sync, active} !== 4'b1110) begin
            errors++;
            $display("FAIL reset_restart: fs/ls/sync/active got %b expected 1110", {fs, ls, sync, active});
        end
        goto(FIRST, AS);
        checks++;
        if (pixel !== mem[0][BPP-1:0]) begin
            errors++;
            $display("FAIL reset_first_pixel: got %h expected %h", pixel, mem[0][BPP-1:0]);
        end
    endtask

    // Random run lengths, random disable gaps and random line contents
    task automatic test_random_run();
        logic [AW+BPP+4:0] got, exp;
        int run, off;
        for (int it = 0; it < 6; it++) begin
            en  = 1'b1;
            run = $urandom_range(100, 2500);
            for (int c = 0; c < run + (off = $urandom_range(1, 15)); c++) begin
                if (c == run) begin
                    en = 1'b0;
                end
                tick();
                if (!en) begin
                    for (int a = 0; a < AL; a++) mem[a] = $urandom;
                end
                got = {rd_en, rd_addr, sync, active, pixel, ls, fs};
                if (m_zero) exp = '0;
                else exp = {m_rd(ev, eh), AW'(exp_addr), m_sync(ev, eh), m_act(ev, eh),
                            m_pix(ev, eh), (eh == 0), (eh == 0 && ev == 0)};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random_cycle it=%0d pos=(%0d,%0d): got %h expected %h", it, ev, eh, got, exp);
                end
            end
        end
        en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        m_run = 0; m_zero = 1; ev = 0; eh = 0; exp_addr = 0;
        for (int a = 0; a < AL; a++) mem[a] = $urandom;
        test_reset();
        test_frame_period();
        test_vsync_shape();
        test_active_fetch();
        test_addr_wrap();
        test_disable_midline();
        test_async_reset();
        test_random_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
